cdb_arbiter: RTL and testbench

- Shares two common-data-bus broadcast channels among four result producers: ALU ex1, ALU ex2, load/store unit, and branch/misc unit.
- Each producer has a small elastic queue. A round-robin scheduler grants up to two queued results per cycle onto registered bus outputs.
- The buses feed the reservation station, the load/store buffer and the ROB wakeup/commit logic.

---
 rtl/cdb_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Shares two common-data-bus broadcast channels among four result producers
// (bit0 = ALU ex1, bit1 = ALU ex2, bit2 = load/store, bit3 = branch/misc).
// Each producer owns a small circular FIFO. A round-robin scheduler pops up
// to two distinct non-empty queues per cycle onto registered bus outputs.
//
// Optional feature: define CDB_STATS_EN to build the grant and stall
// counters. Without it, stat_grants and stat_stalls are tied to 0.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   rdy             global ready; low freezes queues, pointers and buses
//   rollback_flag   misprediction flush; clears queues, drops inputs
//   req_valid[4]    per-producer result valid
//   req_ready[4]    per-producer queue can accept this cycle
//   req_rob_id      packed tags, producer k at [k*ROB_ID_W +: ROB_ID_W]
//   req_result      packed results, producer k at [k*DATA_W +: DATA_W]
//   cdb0_*, cdb1_*  registered broadcast valid / tag / result per bus
//   stat_grants     running count of broadcasts issued
//   stat_stalls     cycles where a valid producer was refused while rdy high
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4,
  parameter int QDEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback_flag,
  input  logic [3:0]            req_valid,
  output logic [3:0]            req_ready,
  input  logic [4*ROB_ID_W-1:0] req_rob_id,
  input  logic [4*DATA_W-1:0]   req_result,
  output logic                  cdb0_valid,
  output logic [ROB_ID_W-1:0]   cdb0_rob_id,
  output logic [DATA_W-1:0]     cdb0_result,
  output logic                  cdb1_valid,
  output logic [ROB_ID_W-1:0]   cdb1_rob_id,
  output logic [DATA_W-1:0]     cdb1_result,
  output logic [31:0]           stat_grants,
  output logic [31:0]           stat_stalls
);

  localparam int NPROD   = 4;
  localparam int PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W   = $clog2(QDEPTH + 1);
  localparam int ENTRY_W = ROB_ID_W + DATA_W;

  // Queue state; an entry is {tag, result}.
  logic [ENTRY_W-1:0] mem        [NPROD][QDEPTH];
  logic [PTR_W-1:0]   head       [NPROD];
  logic [PTR_W-1:0]   tail       [NPROD];
  logic [CNT_W-1:0]   count      [NPROD];
  logic [ENTRY_W-1:0] head_entry [NPROD];

  logic [3:0] nonempty;
  logic [3:0] push;
  logic [3:0] pop;
  logic       run;

  logic [1:0] rr_ptr;
  logic       g0_found;
  logic       g1_found;
  logic [1:0] g0_idx;
  logic [1:0] g1_idx;
  logic [1:0] scan_idx;

  // Normal operation only when ready and not flushing.
  assign run = rdy & ~rollback_flag;

  // Ready comes from the registered count only, never from this cycle's pop,
  // so there is no combinational path from req_valid back to req_ready.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    req_ready  = '0;
    nonempty   = '0;
    push       = '0;
    head_entry = '{default: '0};
    for (int k = 0; k < NPROD; k++) begin
      req_ready[k]  = (count[k] < CNT_W'(QDEPTH)) && run;
      nonempty[k]   = (count[k] != '0);
      head_entry[k] = mem[k][head[k]];
      // Tag 0 means "no dependency": accept the handshake, store nothing.
      push[k] = req_valid[k] && req_ready[k] &&
                (req_rob_id[k*ROB_ID_W +: ROB_ID_W] != '0);
    end
  end

  // Round-robin scan starting at rr_ptr: first hit to bus 0, second to bus 1.
  always_comb begin
    // NOTE: blocking assignments here model ordered combinational evaluation; registers below use <= exclusively.
    g0_found = 1'b0;
    g1_found = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    scan_idx = '0;
    pop      = '0;
    for (int i = 0; i < NPROD; i++) begin
      scan_idx = rr_ptr + 2'(i);
      if (nonempty[scan_idx]) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = scan_idx;
        end else if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = scan_idx;
        end
      end
    end
    if (run) begin
      if (g0_found) pop[g0_idx] = 1'b1;
      if (g1_found) pop[g1_idx] = 1'b1;
    end
  end

  // Queue pointers and occupancy. push/pop are already gated by run.
  always_ff @(posedge clk) begin
    if (rst || rollback_flag) begin
      for (int k = 0; k < NPROD; k++) begin
        head[k]  <= '0;
        tail[k]  <= '0;
        count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NPROD; k++) begin
        if (push[k]) tail[k] <= tail[k] + 1'b1;
        if (pop[k])  head[k] <= head[k] + 1'b1;
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + 1'b1;
          2'b01:   count[k] <= count[k] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; count gates every read, so stale slots are never observed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NPROD; k++) begin
      if (push[k]) begin
        mem[k][tail[k]] <= {req_rob_id[k*ROB_ID_W +: ROB_ID_W],
                            req_result[k*DATA_W +: DATA_W]};
      end
    end
  end

  // Registered buses. Valids pulse once per grant; tag/result hold until the
  // next grant on the same bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb0_valid  <= 1'b0;
      cdb0_rob_id <= '0;
      cdb0_result <= '0;
      cdb1_valid  <= 1'b0;
      cdb1_rob_id <= '0;
      cdb1_result <= '0;
      rr_ptr      <= '0;
    end else if (rollback_flag) begin
      cdb0_valid <= 1'b0;
      cdb1_valid <= 1'b0;
      rr_ptr     <= '0;
    end else if (!rdy) begin
      cdb0_valid <= 1'b0;
      cdb1_valid <= 1'b0;
    end else begin
      cdb0_valid <= g0_found;
      cdb1_valid <= g1_found;
      if (g0_found) {cdb0_rob_id, cdb0_result} <= head_entry[g0_idx];
      if (g1_found) {cdb1_rob_id, cdb1_result} <= head_entry[g1_idx];
      // g1 implies g0, so g0_found covers "any grant".
      if (g0_found) rr_ptr <= (g1_found ? g1_idx : g0_idx) + 2'd1;
    end
  end

`ifdef CDB_STATS_EN
  logic [1:0] grant_cnt;

  assign grant_cnt = run ? ({1'b0, g0_found} + {1'b0, g1_found}) : 2'd0;

  // Cleared by rst only; a rollback leaves the history intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      stat_grants <= stat_grants + 32'(grant_cnt);
      if (rdy && |(req_valid & ~req_ready)) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`else
  assign stat_grants = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter. A table of per-cycle records drives the
// main sequences (contention, backpressure, tag-0 drop, rollback, rdy stall);
// hand-written sequences cover reset state, first-push latency and reset in
// the middle of traffic. Stat counters are checked against running expected
// totals when CDB_STATS_EN is defined, and against 0 otherwise.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int DATA_W   = 32;
  localparam int ROB_ID_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rdy;
  logic                  rollback_flag;
  logic [3:0]            req_valid;
  logic [3:0]            req_ready;
  logic [4*ROB_ID_W-1:0] req_rob_id;
  logic [4*DATA_W-1:0]   req_result;
  logic                  cdb0_valid;
  logic [ROB_ID_W-1:0]   cdb0_rob_id;
  logic [DATA_W-1:0]     cdb0_result;
  logic                  cdb1_valid;
  logic [ROB_ID_W-1:0]   cdb1_rob_id;
  logic [DATA_W-1:0]     cdb1_result;
  logic [31:0]           stat_grants;
  logic [31:0]           stat_stalls;

  cdb_arbiter #(.DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W), .QDEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .rollback_flag (rollback_flag),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rob_id    (req_rob_id),
    .req_result    (req_result),
    .cdb0_valid    (cdb0_valid),
    .cdb0_rob_id   (cdb0_rob_id),
    .cdb0_result   (cdb0_result),
    .cdb1_valid    (cdb1_valid),
    .cdb1_rob_id   (cdb1_rob_id),
    .cdb1_result   (cdb1_result),
    .stat_grants   (stat_grants),
    .stat_stalls   (stat_stalls)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // One cycle: inputs applied before the edge, ready expected before the
  // edge, bus contents expected just after it. tags = {misc, lsu, ex2, ex1}.
  typedef struct {
    logic        rdy;
    logic        rb;
    logic [3:0]  vld;
    logic [15:0] tags;
    logic [3:0]  ready;
    logic        v0;
    logic [3:0]  t0;
    logic        v1;
    logic [3:0]  t1;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int exp_grants = 0;
  int exp_stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] res_of(input logic [3:0] tag);
    return {16'hBEEF, 12'h000, tag};
  endfunction

  task automatic drive(input logic r, input logic rb, input logic [3:0] v, input logic [15:0] tags);
    rdy           = r;
    rollback_flag = rb;
    req_valid     = v;
    req_rob_id    = tags;
    for (int k = 0; k < 4; k++) req_result[k*DATA_W +: DATA_W] = res_of(tags[k*4 +: 4]);
  endtask

  task automatic check_stats(input string name);
`ifdef CDB_STATS_EN
    check({name, " grants"}, stat_grants, 32'(exp_grants));
    check({name, " stalls"}, stat_stalls, 32'(exp_stalls));
`else
    check({name, " grants"}, stat_grants, 32'd0);
    check({name, " stalls"}, stat_stalls, 32'd0);
`endif
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'b0000, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_grants = 0;
    exp_stalls = 0;
    #1;
    check("rst ready", req_ready, 32'hF);
    check("rst v0", cdb0_valid, 0);
    check("rst v1", cdb1_valid, 0);
    check("rst tag0", cdb0_rob_id, 0);
    check("rst res0", cdb0_result, 0);
    check("rst tag1", cdb1_rob_id, 0);
    check("rst res1", cdb1_result, 0);
    check_stats("rst");
  endtask

  initial begin
    //               rdy  rb    vld      tags      ready    v0    t0    v1    t1
    // Four-way contention from rr_ptr=0.
    vecs[0]  = '{1'b1, 1'b0, 4'b1111, 16'h6521, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[1]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b1, 4'h1, 1'b1, 4'h2};
    vecs[2]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b1, 4'h5, 1'b1, 4'h6};
    vecs[3]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};
    // Backpressure: lsu fills to 2 and is refused once; lsu order 8, 9, A.
    vecs[4]  = '{1'b1, 1'b0, 4'b0111, 16'h0821, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[5]  = '{1'b1, 1'b0, 4'b0111, 16'h0943, 4'b1111, 1'b1, 4'h1, 1'b1, 4'h2};
    vecs[6]  = '{1'b1, 1'b0, 4'b0100, 16'h0A00, 4'b1011, 1'b1, 4'h8, 1'b1, 4'h3};
    vecs[7]  = '{1'b1, 1'b0, 4'b0100, 16'h0A00, 4'b1111, 1'b1, 4'h4, 1'b1, 4'h9};
    vecs[8]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b1, 4'hA, 1'b0, 4'h0};
    vecs[9]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};
    // Tag 0 on misc is swallowed; only tag 7 from ex1 is broadcast.
    vecs[10] = '{1'b1, 1'b0, 4'b1001, 16'h0007, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[11] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b1, 4'h7, 1'b0, 4'h0};
    vecs[12] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};
    // Rollback with three queued entries and a simultaneous ex2 push.
    vecs[13] = '{1'b1, 1'b0, 4'b0111, 16'h0321, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[14] = '{1'b1, 1'b1, 4'b0010, 16'h0050, 4'b0000, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[15] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[16] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[17] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};
    // rdy low for two cycles with two queued entries; pushes while low drop.
    vecs[18] = '{1'b1, 1'b0, 4'b0011, 16'h00CB, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[19] = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[20] = '{1'b0, 1'b0, 4'b0011, 16'h00ED, 4'b0000, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[21] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b1, 4'hB, 1'b1, 4'hC};
    vecs[22] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0};

    rst = 1'b1;
    drive(1'b1, 1'b0, 4'b0000, 16'h0000);
    reset_dut();

    // First push: ex1 tag 3 / 0x11 enters at one edge, broadcasts at the next.
    @(negedge clk);
    drive(1'b1, 1'b0, 4'b0001, 16'h0003);
    req_result[31:0] = 32'h11;
    @(posedge clk); #1;
    check("lat push-edge v0", cdb0_valid, 0);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'b0000, 16'h0000);
    @(posedge clk); #1;
    check("lat v0", cdb0_valid, 1);
    check("lat tag0", cdb0_rob_id, 3);
    check("lat res0", cdb0_result, 32'h11);
    check("lat v1", cdb1_valid, 0);
    @(posedge clk); #1;
    check("lat pulse v0", cdb0_valid, 0);
    check("lat hold tag0", cdb0_rob_id, 3);

    // Table run starts from a clean reset so rr_ptr is 0.
    reset_dut();
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rdy, vecs[i].rb, vecs[i].vld, vecs[i].tags);
      #1;
      check($sformatf("row%0d ready", i), req_ready, 32'(vecs[i].ready));
      if (vecs[i].rdy && |(vecs[i].vld & ~vecs[i].ready)) exp_stalls++;
      exp_grants += int'(vecs[i].v0) + int'(vecs[i].v1);
      @(posedge clk); #1;
      check($sformatf("row%0d v0", i), cdb0_valid, 32'(vecs[i].v0));
      check($sformatf("row%0d v1", i), cdb1_valid, 32'(vecs[i].v1));
      if (vecs[i].v0) begin
        check($sformatf("row%0d tag0", i), cdb0_rob_id, 32'(vecs[i].t0));
        check($sformatf("row%0d res0", i), cdb0_result, res_of(vecs[i].t0));
      end
      if (vecs[i].v1) begin
        check($sformatf("row%0d tag1", i), cdb1_rob_id, 32'(vecs[i].t1));
        check($sformatf("row%0d res1", i), cdb1_result, res_of(vecs[i].t1));
      end
      check_stats($sformatf("row%0d", i));
    end

    // Reset in the middle of traffic: queued entries never appear.
    @(negedge clk);
    drive(1'b1, 1'b0, 4'b0011, 16'h0021);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'b0000, 16'h0000);
    @(posedge clk); #1;
    check("midrst v0", cdb0_valid, 0);
    check("midrst v1", cdb1_valid, 0);
    check("midrst tag0", cdb0_rob_id, 0);
    check("midrst tag1", cdb1_rob_id, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_grants = 0;
    exp_stalls = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("midrst idle%0d v0", c), cdb0_valid, 0);
      check($sformatf("midrst idle%0d v1", c), cdb1_valid, 0);
    end
    check("midrst ready", req_ready, 32'hF);
    check_stats("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
